// File: rtl/dtree_seq_walker.sv
// Sequential decision-tree classifier: loads NUM_FEAT feature bytes serially, then walks an
// external node ROM one node per cycle through a single shared threshold comparator.
//
// state | meaning
// IDLE  | post-reset, moves to LOAD on the next clock
// LOAD  | accepting feature bytes into the feature store
// WALK  | evaluating one node per cycle from the node ROM
// DONE  | result held on out_class/out_err until out_ready
module dtree_seq_walker #(
    parameter int NUM_FEAT  = 18,
    parameter int AW        = 7,
    parameter int CLASS_W   = 2,
    parameter int MAX_DEPTH = 15,
    parameter int ROOT_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic [AW-1:0]      node_addr,
    input  logic [18+2*AW-1:0] node_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic               out_err
);

    localparam int NW = 18 + 2*AW;
    localparam int CW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int DW = $clog2(MAX_DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WALK = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] depth;
    logic [7:0]    feat [NUM_FEAT];

    // Node word: leaf flag in the MSB, one reserved bit, then fidx/shift/thr/left/right packed down to bit 0.
    logic          n_leaf;
    logic          unused_rsv;
    logic [4:0]    n_fidx;
    logic [2:0]    n_shift;
    logic [7:0]    n_thr;
    logic [AW-1:0] n_left;
    logic [AW-1:0] n_right;

    assign n_leaf     = node_data[NW-1];
    assign unused_rsv = node_data[NW-2];
    assign n_fidx     = node_data[2*AW+15:2*AW+11];
    assign n_shift    = node_data[2*AW+10:2*AW+8];
    assign n_thr      = node_data[2*AW+7:2*AW];
    assign n_left     = node_data[2*AW-1:AW];
    assign n_right    = node_data[AW-1:0];

    logic [7:0] feat_sel;
    logic [7:0] feat_shifted;
    logic       go_left;
    logic       bad_fidx;
    logic       depth_full;
    logic       accept;

    always_comb begin
        feat_sel = '0;
        for (int i = 0; i < NUM_FEAT; i++) begin
            if (n_fidx == 5'(i)) feat_sel = feat[i];
        end
    end

    assign feat_shifted = feat_sel >> n_shift;
    assign go_left      = (feat_shifted <= n_thr);
    assign bad_fidx     = (int'(n_fidx) >= NUM_FEAT);
    assign depth_full   = (depth == DW'(MAX_DEPTH));

    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;

    // Feature store has no reset; every entry is rewritten before a walk can read it.
    always_ff @(posedge clk) begin
        if (accept) feat[cnt] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            depth     <= '0;
            node_addr <= AW'(ROOT_ADDR);
            out_class <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_LOAD;
                S_LOAD: begin
                    if (accept) begin
                        if (cnt == CW'(NUM_FEAT - 1)) begin
                            cnt       <= '0;
                            depth     <= '0;
                            node_addr <= AW'(ROOT_ADDR);
                            state     <= S_WALK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_WALK: begin
                    if (n_leaf) begin
                        out_class <= n_thr[CLASS_W-1:0];
                        out_err   <= 1'b0;
                        state     <= S_DONE;
                    end else if (bad_fidx || depth_full) begin
                        out_class <= '0;
                        out_err   <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        node_addr <= go_left ? n_left : n_right;
                        depth     <= depth + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        cnt   <= '0;
                        state <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
